// File: rtl/compute_ctrl_pkg.sv
// Shared types for the tiled compute controller: FSM states, latched command and default widths.
package compute_ctrl_pkg;

    localparam int CMD_ADDR_W = 16;
    localparam int CMD_ROW_W  = 16;
    localparam int CMD_TILE_W = 8;

    localparam logic PULSE_IDLE = 1'b0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        W_FILL  = 2'd1,
        COMPUTE = 2'd2,
        FINISH  = 2'd3
    } ctrl_state_e;

    typedef struct packed {
        logic [CMD_ROW_W-1:0]  num_row;
        logic [CMD_TILE_W-1:0] num_tiles;
        logic [CMD_ADDR_W-1:0] acc_base;
        logic                  accumulate;
        logic                  w_resident;
    } tile_cmd_t;

endpackage

// File: rtl/accum_addr_gen.sv
// Accumulator write-address generator: wrapping row counter plus base offset, with registered
// strobe, address and add/overwrite flag.
module accum_addr_gen
    import compute_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = CMD_ADDR_W,
    parameter int ROW_WIDTH  = CMD_ROW_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  add,
    input  logic [ROW_WIDTH-1:0]  num_row,
    input  logic [ADDR_WIDTH-1:0] base,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_add
);

    logic [ROW_WIDTH-1:0] row_q;
    logic [ROW_WIDTH-1:0] row_p1;
    logic [ROW_WIDTH-1:0] row_nxt;

    // num_row==0 needs no special case: row_p1 only equals 0 on natural overflow.
    assign row_p1  = row_q + ROW_WIDTH'(1);
    assign row_nxt = (row_p1 == num_row) ? '0 : row_p1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            row_q   <= '0;
            wr_en   <= PULSE_IDLE;
            wr_addr <= '0;
            wr_add  <= 1'b0;
        end else begin
            wr_en <= en;
            if (en) begin
                wr_addr <= base + ADDR_WIDTH'(row_q);
                wr_add  <= add;
            end
            if (clr) begin
                row_q <= '0;
            end else if (en) begin
                row_q <= row_nxt;
            end
        end
    end

endmodule

// File: rtl/tiled_compute_ctrl.sv
// Multi-tile systolic-array sequencer: weight fill, compute and accumulator writeback per tile,
// with ping-pong weight prefetch. Optional perf counters under TILED_COMPUTE_CTRL_PERF_EN.
module tiled_compute_ctrl
    import compute_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = CMD_ADDR_W,
    parameter int ROW_WIDTH  = CMD_ROW_W,
    parameter int TILE_WIDTH = CMD_TILE_W,
    parameter int SYS_ROW    = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ROW_WIDTH-1:0]  cmd_num_row,
    input  logic [TILE_WIDTH-1:0] cmd_num_tiles,
    input  logic [ADDR_WIDTH-1:0] cmd_acc_base,
    input  logic                  cmd_accumulate,
    input  logic                  cmd_w_resident,
    input  logic                  drain_done,
    input  logic                  sys_done,
    input  logic                  sys_en_out,
    output logic                  fifo_in_ctrl_en,
    output logic                  fifo_out_ctrl_en,
    output logic                  mem_rd_ctrl_en,
    output logic [ADDR_WIDTH-1:0] w_offset_addr,
    output logic                  accum_wr_en,
    output logic [ADDR_WIDTH-1:0] accum_wr_addr,
    output logic                  accum_wr_add,
    output logic [TILE_WIDTH-1:0] tile_idx,
    output logic                  busy,
    output logic                  done
`ifdef TILED_COMPUTE_CTRL_PERF_EN
   ,output logic [31:0]           perf_fill_cycles,
    output logic [31:0]           perf_compute_cycles
`endif
);

    localparam logic [TILE_WIDTH:0] TILE_ONE = (TILE_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] HALF_OFFSET = ADDR_WIDTH'(SYS_ROW);

    ctrl_state_e           state_q, state_d;
    tile_cmd_t             cmd_q, cmd_d, cmd_in;
    logic [TILE_WIDTH-1:0] tile_q, tile_d;
    logic                  drain_q, drain_d;
    logic                  fifo_en_q, fifo_en_d;
    logic                  mem_rd_d;
    logic                  done_d;
    logic [ADDR_WIDTH-1:0] w_off_d;
    logic                  row_clr;
    logic                  accept;

    logic [TILE_WIDTH:0]   tile_p1, tile_p2, num_tiles_x;

    assign cmd_in = '{num_row:    cmd_num_row,
                      num_tiles:  cmd_num_tiles,
                      acc_base:   cmd_acc_base,
                      accumulate: cmd_accumulate,
                      w_resident: cmd_w_resident};

    // Tile arithmetic carries one extra bit so a full 2^TILE_WIDTH-1 loop cannot overflow.
    assign tile_p1     = {1'b0, tile_q} + TILE_ONE;
    assign tile_p2     = tile_p1 + TILE_ONE;
    assign num_tiles_x = {1'b0, cmd_q.num_tiles};

    // w_resident only matters on the accept cycle; the latched copy is kept for visibility.
    logic unused_w_resident;
    assign unused_w_resident = cmd_q.w_resident;

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred on untaken paths.
        state_d   = state_q;
        cmd_d     = cmd_q;
        tile_d    = tile_q;
        drain_d   = drain_q;
        fifo_en_d = PULSE_IDLE;
        mem_rd_d  = PULSE_IDLE;
        done_d    = PULSE_IDLE;
        w_off_d   = w_offset_addr;
        row_clr   = 1'b0;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept  = 1'b1;
                    cmd_d   = cmd_in;
                    tile_d  = '0;
                    row_clr = 1'b1;
                    drain_d = cmd_w_resident;
                    if (cmd_num_tiles == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = W_FILL;
                        if (!cmd_w_resident) begin
                            fifo_en_d = 1'b1;
                            w_off_d   = '0;
                        end
                    end
                end
            end

            W_FILL: begin
                if (drain_q || drain_done) begin
                    drain_d  = 1'b0;
                    mem_rd_d = 1'b1;
                    state_d  = COMPUTE;
                    if (tile_p1 < num_tiles_x) begin
                        fifo_en_d = 1'b1;
                        w_off_d   = tile_q[0] ? '0 : HALF_OFFSET;
                    end
                end
            end

            COMPUTE: begin
                if (drain_done) begin
                    drain_d = 1'b1;
                end
                if (sys_done) begin
                    if (tile_p1 == num_tiles_x) begin
                        state_d = FINISH;
                    end else begin
                        tile_d  = tile_p1[TILE_WIDTH-1:0];
                        row_clr = 1'b1;
                        // Prefetched weights already drained: start the next tile without a fill gap.
                        if (drain_q || drain_done) begin
                            drain_d  = 1'b0;
                            mem_rd_d = 1'b1;
                            if (tile_p2 < num_tiles_x) begin
                                fifo_en_d = 1'b1;
                                w_off_d   = tile_q[0] ? HALF_OFFSET : '0;
                            end
                        end else begin
                            state_d = W_FILL;
                        end
                    end
                end
            end

            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= IDLE;
            cmd_q          <= '0;
            tile_q         <= '0;
            drain_q        <= 1'b0;
            fifo_en_q      <= PULSE_IDLE;
            mem_rd_ctrl_en <= PULSE_IDLE;
            done           <= PULSE_IDLE;
            w_offset_addr  <= '0;
            busy           <= 1'b0;
            cmd_ready      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            tile_q         <= tile_d;
            drain_q        <= drain_d;
            fifo_en_q      <= fifo_en_d;
            mem_rd_ctrl_en <= mem_rd_d;
            done           <= done_d;
            w_offset_addr  <= w_off_d;
            busy           <= (state_d != IDLE);
            cmd_ready      <= (state_d == IDLE);
        end
    end

    assign fifo_in_ctrl_en  = fifo_en_q;
    assign fifo_out_ctrl_en = fifo_en_q;
    assign tile_idx         = tile_q;

    accum_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ROW_WIDTH  (ROW_WIDTH)
    ) u_accum_addr_gen (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (row_clr),
        .en      ((state_q == COMPUTE) && sys_en_out),
        .add     ((tile_q != '0) || cmd_q.accumulate),
        .num_row (cmd_q.num_row),
        .base    (cmd_q.acc_base),
        .wr_en   (accum_wr_en),
        .wr_addr (accum_wr_addr),
        .wr_add  (accum_wr_add)
    );

`ifdef TILED_COMPUTE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rstn || accept) begin
            perf_fill_cycles    <= '0;
            perf_compute_cycles <= '0;
        end else begin
            if (state_q == W_FILL && perf_fill_cycles != '1) begin
                perf_fill_cycles <= perf_fill_cycles + 32'd1;
            end
            if (state_q == COMPUTE && perf_compute_cycles != '1) begin
                perf_compute_cycles <= perf_compute_cycles + 32'd1;
            end
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_tiled_compute_ctrl.sv
// Directed self-checking bench for tiled_compute_ctrl: single/multi tile, prefetch, stall,
// address wrap, empty command and mid-operation reset.
module tb_tiled_compute_ctrl;

    logic        clk;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_num_row;
    logic [7:0]  cmd_num_tiles;
    logic [15:0] cmd_acc_base;
    logic        cmd_accumulate;
    logic        cmd_w_resident;
    logic        drain_done;
    logic        sys_done;
    logic        sys_en_out;
    logic        fifo_in_ctrl_en;
    logic        fifo_out_ctrl_en;
    logic        mem_rd_ctrl_en;
    logic [15:0] w_offset_addr;
    logic        accum_wr_en;
    logic [15:0] accum_wr_addr;
    logic        accum_wr_add;
    logic [7:0]  tile_idx;
    logic        busy;
    logic        done;
`ifdef TILED_COMPUTE_CTRL_PERF_EN
    logic [31:0] perf_fill_cycles;
    logic [31:0] perf_compute_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    tiled_compute_ctrl dut (
        .clk              (clk),
        .rstn             (rstn),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_num_row      (cmd_num_row),
        .cmd_num_tiles    (cmd_num_tiles),
        .cmd_acc_base     (cmd_acc_base),
        .cmd_accumulate   (cmd_accumulate),
        .cmd_w_resident   (cmd_w_resident),
        .drain_done       (drain_done),
        .sys_done         (sys_done),
        .sys_en_out       (sys_en_out),
        .fifo_in_ctrl_en  (fifo_in_ctrl_en),
        .fifo_out_ctrl_en (fifo_out_ctrl_en),
        .mem_rd_ctrl_en   (mem_rd_ctrl_en),
        .w_offset_addr    (w_offset_addr),
        .accum_wr_en      (accum_wr_en),
        .accum_wr_addr    (accum_wr_addr),
        .accum_wr_add     (accum_wr_add),
        .tile_idx         (tile_idx),
        .busy             (busy),
        .done             (done)
`ifdef TILED_COMPUTE_CTRL_PERF_EN
       ,.perf_fill_cycles    (perf_fill_cycles),
        .perf_compute_cycles (perf_compute_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [15:0] rows, input logic [7:0] tiles,
                            input logic [15:0] base, input logic acc, input logic wres);
        cmd_num_row    = rows;
        cmd_num_tiles  = tiles;
        cmd_acc_base   = base;
        cmd_accumulate = acc;
        cmd_w_resident = wres;
        cmd_valid      = 1'b1;
        tick();
        cmd_valid      = 1'b0;
    endtask

    logic [15:0] edge_addr [3];

    initial begin
        rstn = 1'b0; cmd_valid = 1'b0; cmd_num_row = '0; cmd_num_tiles = '0;
        cmd_acc_base = '0; cmd_accumulate = 1'b0; cmd_w_resident = 1'b0;
        drain_done = 1'b0; sys_done = 1'b0; sys_en_out = 1'b0;
        edge_addr[0] = 16'hFFFE; edge_addr[1] = 16'hFFFF; edge_addr[2] = 16'h0000;

        // Reset state
        tick(); tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fifo_in", fifo_in_ctrl_en, 0);
        check("rst_mem_rd", mem_rd_ctrl_en, 0);
        check("rst_wr_en", accum_wr_en, 0);
        check("rst_tile_idx", tile_idx, 0);
        rstn = 1'b1;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1);

        // Single tile, weights not resident
        send_cmd(16'd4, 8'd1, 16'h0100, 1'b0, 1'b0);
        check("t1_fifo_in", fifo_in_ctrl_en, 1);
        check("t1_fifo_out", fifo_out_ctrl_en, 1);
        check("t1_w_off", w_offset_addr, 16'h0000);
        check("t1_busy", busy, 1);
        check("t1_cmd_ready", cmd_ready, 0);
        drain_done = 1'b1;
        tick();
        drain_done = 1'b0;
        check("t1_mem_rd", mem_rd_ctrl_en, 1);
        check("t1_fifo_pulse_end", fifo_in_ctrl_en, 0);
        for (int i = 0; i < 4; i++) begin
            sys_en_out = 1'b1;
            tick();
            check("t1_wr_en", accum_wr_en, 1);
            check("t1_wr_addr", accum_wr_addr, 32'h100 + i);
            check("t1_wr_add", accum_wr_add, 0);
        end
        check("t1_mem_rd_pulse_end", mem_rd_ctrl_en, 0);
        sys_en_out = 1'b0; sys_done = 1'b1;
        tick();
        sys_done = 1'b0;
        check("t1_wr_en_off", accum_wr_en, 0);
        check("t1_done_early", done, 0);
        tick();
        check("t1_done", done, 1);
        check("t1_busy_off", busy, 0);
        tick();
        check("t1_done_pulse_end", done, 0);
        check("t1_cmd_ready_back", cmd_ready, 1);

        // Three tiles, prefetched weights drain during compute
        send_cmd(16'd2, 8'd3, 16'h0020, 1'b0, 1'b0);
        check("t3_fifo_in0", fifo_in_ctrl_en, 1);
        drain_done = 1'b1;
        tick();
        drain_done = 1'b0;
        check("t3_mem_rd0", mem_rd_ctrl_en, 1);
        check("t3_prefetch0", fifo_in_ctrl_en, 1);
        check("t3_w_off0", w_offset_addr, 16'd16);
        sys_en_out = 1'b1;
        tick();
        check("t3_addr0a", accum_wr_addr, 16'h0020);
        drain_done = 1'b1;
        tick();
        check("t3_addr0b", accum_wr_addr, 16'h0021);
        check("t3_add0", accum_wr_add, 0);
        sys_en_out = 1'b0; drain_done = 1'b0; sys_done = 1'b1;
        tick();
        check("t3_mem_rd1", mem_rd_ctrl_en, 1);
        check("t3_prefetch1", fifo_out_ctrl_en, 1);
        check("t3_w_off1", w_offset_addr, 16'd0);
        check("t3_tile1", tile_idx, 1);
        sys_done = 1'b0; sys_en_out = 1'b1; drain_done = 1'b1;
        tick();
        check("t3_gapless_wr1", accum_wr_en, 1);
        check("t3_addr1", accum_wr_addr, 16'h0020);
        check("t3_add1", accum_wr_add, 1);
        sys_en_out = 1'b0; drain_done = 1'b0; sys_done = 1'b1;
        tick();
        check("t3_mem_rd2", mem_rd_ctrl_en, 1);
        check("t3_no_prefetch2", fifo_in_ctrl_en, 0);
        check("t3_tile2", tile_idx, 2);
        sys_done = 1'b0; sys_en_out = 1'b1;
        tick();
        check("t3_gapless_wr2", accum_wr_en, 1);
        check("t3_add2", accum_wr_add, 1);
        sys_en_out = 1'b0; sys_done = 1'b1;
        tick();
        sys_done = 1'b0;
        tick();
        check("t3_done", done, 1);

        // Two tiles, resident weights, tile-1 drain arrives late
        send_cmd(16'd0, 8'd2, 16'h0000, 1'b1, 1'b1);
        check("st_no_fill", fifo_in_ctrl_en, 0);
        tick();
        check("st_mem_rd0", mem_rd_ctrl_en, 1);
        check("st_prefetch", fifo_in_ctrl_en, 1);
        check("st_w_off", w_offset_addr, 16'd16);
        sys_en_out = 1'b1;
        tick();
        check("st_add_acc", accum_wr_add, 1);
        sys_en_out = 1'b0; sys_done = 1'b1;
        tick();
        sys_done = 1'b0;
        check("st_no_mem_rd", mem_rd_ctrl_en, 0);
        check("st_tile1", tile_idx, 1);
        sys_en_out = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("st_wait_mem_rd", mem_rd_ctrl_en, 0);
            check("st_wait_busy", busy, 1);
            check("st_ignore_en", accum_wr_en, 0);
        end
        sys_en_out = 1'b0; drain_done = 1'b1;
        tick();
        drain_done = 1'b0;
        check("st_mem_rd1", mem_rd_ctrl_en, 1);
        check("st_no_prefetch1", fifo_in_ctrl_en, 0);
        sys_done = 1'b1;
        tick();
        sys_done = 1'b0;
        tick();
        check("st_done", done, 1);

        // Row wrap at num_row=3
        send_cmd(16'd3, 8'd1, 16'h0010, 1'b0, 1'b1);
        tick();
        check("wr_mem_rd", mem_rd_ctrl_en, 1);
        sys_en_out = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("wr_addr", accum_wr_addr, 32'h10 + (i % 3));
        end
        sys_en_out = 1'b0; sys_done = 1'b1;
        tick();
        sys_done = 1'b0;
        tick();
        check("wr_done", done, 1);

        // Base near top of address space
        send_cmd(16'd4, 8'd1, 16'hFFFE, 1'b0, 1'b1);
        tick();
        sys_en_out = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("base_wrap_addr", accum_wr_addr, edge_addr[i]);
        end
        sys_en_out = 1'b0; sys_done = 1'b1;
        tick();
        sys_done = 1'b0;
        tick();
        check("base_done", done, 1);

        // Empty command with cmd_valid held through busy
        cmd_num_tiles = 8'd0; cmd_w_resident = 1'b0; cmd_valid = 1'b1;
        tick();
        check("z_busy", busy, 1);
        check("z_fifo", fifo_in_ctrl_en, 0);
        check("z_ready", cmd_ready, 0);
        tick();
        cmd_valid = 1'b0;
        check("z_done", done, 1);
        check("z_mem_rd", mem_rd_ctrl_en, 0);
        check("z_fifo2", fifo_out_ctrl_en, 0);
        tick();
        check("z_no_reaccept", busy, 0);
        check("z_done_end", done, 0);

        // Reset in the middle of COMPUTE
        send_cmd(16'd2, 8'd2, 16'h0000, 1'b0, 1'b1);
        tick();
        check("ra_mem_rd", mem_rd_ctrl_en, 1);
        sys_en_out = 1'b1; rstn = 1'b0;
        tick();
        check("ra_wr_en", accum_wr_en, 0);
        check("ra_busy", busy, 0);
        check("ra_ready", cmd_ready, 0);
        check("ra_w_off", w_offset_addr, 0);
        check("ra_fifo", fifo_in_ctrl_en, 0);
        check("ra_mem_rd_off", mem_rd_ctrl_en, 0);
        rstn = 1'b1; sys_en_out = 1'b0;
        tick();
        check("ra_ready_back", cmd_ready, 1);
        check("ra_no_done", done, 0);
        tick();
        check("ra_no_done2", done, 0);
        send_cmd(16'd2, 8'd1, 16'h0040, 1'b0, 1'b0);
        check("ra_new_fifo", fifo_in_ctrl_en, 1);
        drain_done = 1'b1;
        tick();
        drain_done = 1'b0;
        check("ra_new_mem_rd", mem_rd_ctrl_en, 1);
        sys_en_out = 1'b1;
        tick();
        check("ra_new_addr0", accum_wr_addr, 16'h0040);
        tick();
        check("ra_new_addr1", accum_wr_addr, 16'h0041);
        sys_en_out = 1'b0; sys_done = 1'b1;
        tick();
        sys_done = 1'b0;
        tick();
        check("ra_new_done", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tiled_compute_ctrl.md
Name: tiled_compute_ctrl

Overview:
Command-driven controller that sequences a multi-tile matrix op on the systolic array: weight fill, input read/compute, and accumulator writeback per weight tile. Successor to the single-tile controller.
- Adds a valid/ready command port, a tile loop of up to 2^TILE_WIDTH-1 tiles, and ping-pong weight prefetch of tile N+1 during compute of tile N.
- Adds a based accumulator address with overwrite/accumulate control, and busy/done status.
- Sits between the top-level scheduler and the weight FIFO ctrl, input memory read ctrl and accumulator.

Parameters:
ADDR_WIDTH, 16, accumulator and weight-offset address width
ROW_WIDTH, 16, row-count width
TILE_WIDTH, 8, tile-count width
SYS_ROW, 16, array rows; size of one weight buffer half

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_num_row  in  ROW_WIDTH  rows per tile (accumulator wrap point)
cmd_num_tiles  in  TILE_WIDTH  weight tiles in command
cmd_acc_base  in  ADDR_WIDTH  accumulator base address
cmd_accumulate  in  1  tile 0 adds into existing psums (else overwrites)
cmd_w_resident  in  1  tile 0 weights already loaded
drain_done  in  1  weight tile drained into array (pulse)
sys_done  in  1  tile compute finished (pulse)
sys_en_out  in  1  array emits one valid psum row
fifo_in_ctrl_en  out  1  start weight FIFO fill (pulse)
fifo_out_ctrl_en  out  1  start weight FIFO drain (pulse)
mem_rd_ctrl_en  out  1  start input read (pulse)
w_offset_addr  out  ADDR_WIDTH  weight buffer half for current fill
accum_wr_en  out  1  accumulator write strobe
accum_wr_addr  out  ADDR_WIDTH  accumulator write address
accum_wr_add  out  1  1=read-add-write, 0=overwrite
tile_idx  out  TILE_WIDTH  tile being computed
busy  out  1  state != IDLE
done  out  1  command complete (one-cycle pulse)

Behaviour:
- All outputs are registered. Every response appears 1 cycle after the causing input/state.
- Reset: state IDLE; all pulses, accum_wr_en, accum_wr_addr, w_offset_addr, tile_idx, busy and done are 0; cmd_ready is 0 while rstn=0 and 1 the first cycle after.
- Reset mid-operation aborts the command; no done pulse.
- States: IDLE, W_FILL, COMPUTE, FINISH.
- IDLE: cmd_ready=1. On accept:
  - Latch all cmd_* fields; tile_idx=0; row counter=0.
  - num_tiles==0: go FINISH directly; no enables asserted.
  - Else go W_FILL.
  - If !cmd_w_resident, pulse fifo_in/out_ctrl_en with w_offset_addr=0.
  - If cmd_w_resident, pre-set the internal drain flag.
- cmd_ready is 0 in all states other than IDLE. cmd_valid is ignored there.
- W_FILL: sample drain_done into the drain flag. When the flag is set:
  - Clear the flag, pulse mem_rd_ctrl_en, go COMPUTE.
  - If tile_idx+1 < num_tiles, also pulse fifo_in/out_ctrl_en with w_offset_addr = ((tile_idx+1) mod 2)*SYS_ROW (prefetch).
- COMPUTE: drain_done sets the drain flag (prefetched tile ready). On sys_done:
  - Last tile (tile_idx==num_tiles-1): go FINISH.
  - Else: tile_idx++ and row counter=0.
  - If the drain flag is already set, or drain_done arrives the same cycle: go straight to COMPUTE via W_FILL-equivalent actions in the same cycle (mem_rd pulse plus next prefetch). Otherwise go W_FILL.
- FINISH: done=1 for one cycle; go IDLE.
- Accumulator path, active in COMPUTE only:
  - Each sys_en_out cycle: accum_wr_en=1, accum_wr_addr=acc_base+row, then row++.
  - When row+1 == num_row, row wraps to 0.
  - num_row==0 means natural 2^ROW_WIDTH wrap.
  - Address sum is modulo 2^ADDR_WIDTH.
  - accum_wr_add = (tile_idx!=0) | accumulate_latched.
  - sys_en_out outside COMPUTE is ignored: accum_wr_en stays 0.
- Pulse outputs are never held for more than 1 cycle.

Optional Feature:
Macro TILED_COMPUTE_CTRL_PERF_EN.
- Defined: adds outputs perf_fill_cycles[31:0] (cycles in W_FILL) and perf_compute_cycles[31:0] (cycles in COMPUTE).
  - Both clear on command accept and on reset.
  - Both saturate at all-ones.
  - Both hold after done.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Package compute_ctrl_pkg:
  - state enum ctrl_state_e {IDLE, W_FILL, COMPUTE, FINISH}
  - packed struct tile_cmd_t (num_row, num_tiles, acc_base, accumulate, w_resident), parameterised via package localparam widths
  - localparam for the pulse reset value
- Sub-module accum_addr_gen: row counter, wrap compare, base add, write strobe register. Reusable by the output/drain controller.

Test Plan:
- Single tile, w_resident=0, num_row=4, base=0x100, 4 sys_en_out pulses:
  - fifo pulses 1 cycle after accept.
  - drain_done → mem_rd pulse.
  - Addresses 0x100..0x103 with accum_wr_add=0.
  - sys_done → done 2 cycles later.
- 3 tiles, drain_done arriving mid-COMPUTE each tile:
  - Prefetch w_offset_addr alternates 16, 0.
  - No W_FILL gap between tiles.
  - accum_wr_add=1 for tiles 1–2.
  - tile_idx 0→1→2.
- 2 tiles, drain_done delayed 10 cycles after tile-0 sys_done: controller waits in W_FILL with busy=1 and mem_rd pulses only after drain_done.
- Wrap and base edge cases:
  - num_row=3 with 7 sys_en_out gives addresses base+0,1,2,0,1,2,0.
  - base=0xFFFE wraps to 0x0000.
- num_tiles=0: done 2 cycles after accept with no enables. cmd_valid held during busy is not accepted twice.
- rstn low mid-COMPUTE: next cycle all outputs 0, no done; cmd_ready=1 after release; a new command runs normally.
